// File: rtl/ct_f_spsram_init_ctrl.sv
// rtl/ct_f_spsram_init_ctrl.sv - init sweep and request pass-through in front of a single-port SRAM
// Walks every address writing INIT_VAL, then forwards functional requests with zero added latency.
module ct_f_spsram_init_ctrl #(
  parameter int                    ADDR_WIDTH    = 12,
  parameter int                    DATA_WIDTH    = 84,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL      = '0,
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wen,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_cnt_nxt;
  logic                  rd_fire;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= IDLE;
      init_cnt <= '0;
      rd_vld   <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      rd_vld   <= rd_fire;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_done    = 1'b0;
    req_rdy      = 1'b0;
    sram_cen     = 1'b1;
    sram_gwen    = 1'b1;
    sram_wen     = '1;
    sram_a       = init_cnt;
    sram_d       = INIT_VAL;
    unique case (state)
      IDLE: begin
        state_nxt = INIT_ON_RESET ? INIT : RUN;
      end
      INIT: begin
        sram_cen     = 1'b0;
        sram_gwen    = 1'b0;
        sram_wen     = '0;
        init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
        // last address written this cycle; counter wraps to 0 on its own
        if (&init_cnt) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
        req_rdy   = 1'b1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (req_vld) begin
          sram_cen  = 1'b0;
          sram_gwen = ~req_wr;
          sram_wen  = req_wr ? req_wen : '1;
        end
        if (init_req) begin
          state_nxt    = INIT;
          init_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rd_fire = req_vld & req_rdy & ~req_wr;
  assign rd_data = sram_q;

endmodule

// File: tb/tb_ct_f_spsram_init_ctrl.sv
// tb/tb_ct_f_spsram_init_ctrl.sv - self-checking bench for ct_f_spsram_init_ctrl
// Behavioural SRAM plus an expected-contents array; per-feature tasks check inline.
module tb_ct_f_spsram_init_ctrl;
  localparam int AW = 12;
  localparam int DW = 84;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT_VAL = '0;
  localparam logic [DW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req = 1'b0;
  logic init_done, req_rdy, rd_vld;
  logic req_vld = 1'b0, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, req_wen = '1;
  logic [DW-1:0] rd_data, sram_d, sram_wen;
  logic [DW-1:0] sram_q;
  logic [AW-1:0] sram_a;
  logic sram_cen, sram_gwen;

  logic rst0_n = 1'b0;
  logic init_done0, req_rdy0, rd_vld0;
  logic req0_vld = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] rd_data0, sram_d0, sram_wen0;
  logic [DW-1:0] q0_pat = '0;
  logic [AW-1:0] sram_a0;
  logic sram_cen0, sram_gwen0;
  int writes0;

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];

  always #5 clk = ~clk;

  ct_f_spsram_init_ctrl dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .init_req(init_req), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen), .rd_vld(rd_vld), .rd_data(rd_data),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_d(sram_d), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_q(sram_q)
  );

  ct_f_spsram_init_ctrl #(.INIT_ON_RESET(1'b0)) dut0 (
    .forever_cpuclk(clk), .cpurst_b(rst0_n), .init_req(1'b0), .init_done(init_done0),
    .req_vld(req0_vld), .req_rdy(req_rdy0), .req_wr(1'b0), .req_addr(req0_addr),
    .req_wdata(ONES), .req_wen(ONES), .rd_vld(rd_vld0), .rd_data(rd_data0),
    .sram_a(sram_a0), .sram_cen(sram_cen0), .sram_d(sram_d0), .sram_gwen(sram_gwen0),
    .sram_wen(sram_wen0), .sram_q(q0_pat)
  );

  // single-port SRAM: registered read data, per-bit active-low write enables
  always @(posedge clk) begin
    if (sram_cen === 1'b0) begin
      if (sram_gwen === 1'b0) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= sram_mem[sram_a];
    end
  end

  always @(negedge clk) begin
    if (!rst0_n) writes0 <= 0;
    else if (sram_cen0 === 1'b0 && sram_gwen0 === 1'b0) writes0 <= writes0 + 1;
  end

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] w);
    exp_mem[a] = (exp_mem[a] & w) | (d & ~w);
  endfunction

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = INIT_VAL;
  endfunction

  task automatic drive_req(input logic v, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] w);
    req_vld = v; req_wr = wr; req_addr = a; req_wdata = d; req_wen = w;
  endtask

  // Steps negedges while init_done is low, tallying sweep writes and their ordering.
  task automatic observe_sweep(input int pulse_at, output int cycles, output int writes,
                               output int order_err, output int rdy_hi);
    cycles = 0; writes = 0; order_err = 0; rdy_hi = 0;
    @(negedge clk);
    while (init_done !== 1'b1 && cycles < 5000) begin
      if (req_rdy !== 1'b0) rdy_hi++;
      if (sram_cen === 1'b0 && sram_gwen === 1'b0) begin
        if (sram_a !== AW'(writes) || sram_d !== INIT_VAL || sram_wen !== '0) order_err++;
        writes++;
      end
      cycles++;
      init_req = (cycles == pulse_at);
      @(negedge clk);
    end
    init_req = 1'b0;
  endtask

  task automatic test_reset();
    int cyc, wr, oerr, rdy;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_cen, sram_gwen, sram_wen, init_done, req_rdy, rd_vld} !== {2'b11, ONES, 3'b000})
      $display("FAIL reset_outputs: got cen=%b gwen=%b wen=%h done=%b rdy=%b rdvld=%b, want 1 1 all-ones 0 0 0",
               sram_cen, sram_gwen, sram_wen, init_done, req_rdy, rd_vld);
    else passed++;
    rst_n = 1'b1; #1;
    checks++;
    if ({sram_cen, init_done} !== 2'b10) $display("FAIL idle_cycle: got cen=%b done=%b, want 1 0", sram_cen, init_done);
    else passed++;
    observe_sweep(0, cyc, wr, oerr, rdy);
    checks++;
    if (cyc !== DEPTH) $display("FAIL init_cycles: got %0d, want %0d", cyc, DEPTH); else passed++;
    checks++;
    if (wr !== DEPTH || oerr !== 0) $display("FAIL init_writes: got %0d writes %0d out of order, want %0d 0", wr, oerr, DEPTH); else passed++;
    checks++;
    if (rdy !== 0 || {init_done, req_rdy} !== 2'b11)
      $display("FAIL init_rdy: got rdy-high-in-init=%0d done=%b rdy=%b, want 0 1 1", rdy, init_done, req_rdy);
    else passed++;
    model_init();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pat;
    pat = 84'h5A5A5A5A5A5A5A5A5A5A5;
    @(posedge clk); #1; drive_req(1'b1, 1'b1, 12'h123, pat, '0);
    @(negedge clk);
    checks++;
    if ({sram_cen, sram_gwen, sram_a, sram_d, sram_wen} !== {2'b00, 12'h123, pat, {DW{1'b0}}})
      $display("FAIL write_pins: got cen=%b gwen=%b a=%h d=%h wen=%h", sram_cen, sram_gwen, sram_a, sram_d, sram_wen);
    else passed++;
    model_write(12'h123, pat, '0);
    @(posedge clk); #1; drive_req(1'b1, 1'b0, 12'h123, rand_word(), rand_word());
    @(negedge clk);
    checks++;
    if (rd_vld !== 1'b0) $display("FAIL write_no_rdvld: got %b, want 0", rd_vld); else passed++;
    checks++;
    if ({sram_cen, sram_gwen, sram_a, sram_wen} !== {2'b01, 12'h123, ONES})
      $display("FAIL read_pins: got cen=%b gwen=%b a=%h wen=%h", sram_cen, sram_gwen, sram_a, sram_wen);
    else passed++;
    @(posedge clk); #1; drive_req(1'b0, 1'b0, '0, '0, '1);
    @(negedge clk);
    checks++;
    if ({rd_vld, rd_data} !== {1'b1, pat} || rd_data !== exp_mem[12'h123])
      $display("FAIL read_data: got vld=%b data=%h, want 1 %h", rd_vld, rd_data, pat);
    else passed++;
    checks++;
    if (sram_cen !== 1'b1) $display("FAIL idle_cen: got %b, want 1", sram_cen); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rd_vld !== 1'b0) $display("FAIL read_single_pulse: got %b, want 0", rd_vld); else passed++;
    @(posedge clk); #1; drive_req(1'b1, 1'b1, 12'h123, ONES, ~84'hF);
    model_write(12'h123, ONES, ~84'hF);
    @(posedge clk); #1; drive_req(1'b1, 1'b0, 12'h123, '0, '0);
    @(posedge clk); #1; drive_req(1'b0, 1'b0, '0, '0, '1);
    @(negedge clk);
    checks++;
    if ({rd_vld, rd_data} !== {1'b1, 84'h5A5A5A5A5A5A5A5A5A5AF} || rd_data !== exp_mem[12'h123])
      $display("FAIL partial_write: got vld=%b data=%h, want 1 5a5a5a5a5a5a5a5a5a5af", rd_vld, rd_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; drive_req(1'b1, 1'b1, AW'(i), DW'(i), '0);
      model_write(AW'(i), DW'(i), '0);
    end
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) drive_req(1'b1, 1'b0, AW'(i), '0, '0);
      else drive_req(1'b0, 1'b0, '0, '0, '1);
      if (i > 0) begin
        @(negedge clk);
        checks++;
        if ({rd_vld, rd_data} !== {1'b1, exp_mem[i-1]})
          $display("FAIL b2b_read%0d: got vld=%b data=%h, want 1 %h", i - 1, rd_vld, rd_data, exp_mem[i-1]);
        else passed++;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rd_vld !== 1'b0) $display("FAIL b2b_end: got rd_vld=%b, want 0", rd_vld); else passed++;
  endtask

  task automatic test_random();
    logic exp_vld, v, wr;
    logic [DW-1:0] exp_q, d, w;
    logic [AW-1:0] a;
    exp_vld = 1'b0; exp_q = '0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      v = ($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15));
      d = rand_word();
      w = ($urandom_range(0, 1) != 0) ? '0 : rand_word();
      drive_req(v, wr, a, d, w);
      @(negedge clk);
      checks++;
      if (rd_vld !== exp_vld || (exp_vld && rd_data !== exp_q) || sram_cen !== ~v)
        $display("FAIL random_%0d: got vld=%b data=%h cen=%b, want vld=%b data=%h cen=%b",
                 n, rd_vld, rd_data, sram_cen, exp_vld, exp_q, ~v);
      else passed++;
      exp_vld = v & ~wr;
      if (v && !wr) exp_q = exp_mem[a];
      if (v && wr) model_write(a, d, w);
    end
    @(posedge clk); #1; drive_req(1'b0, 1'b0, '0, '0, '1);
    @(negedge clk);
    checks++;
    if (rd_vld !== exp_vld || (exp_vld && rd_data !== exp_q))
      $display("FAIL random_last: got vld=%b data=%h, want %b %h", rd_vld, rd_data, exp_vld, exp_q);
    else passed++;
  endtask

  task automatic test_init_req();
    int cyc, wr, oerr, rdy;
    @(posedge clk); #1; drive_req(1'b1, 1'b0, 12'h123, '0, '0);
    @(posedge clk); #1; drive_req(1'b1, 1'b1, 12'd5, DW'(8'hFF), '0); init_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_vld, rd_data} !== {1'b1, exp_mem[12'h123]})
      $display("FAIL read_before_init: got vld=%b data=%h, want 1 %h", rd_vld, rd_data, exp_mem[12'h123]);
    else passed++;
    checks++;
    if ({req_rdy, sram_cen, sram_gwen, sram_a} !== {3'b100, 12'd5})
      $display("FAIL write_with_init_req: got rdy=%b cen=%b gwen=%b a=%h", req_rdy, sram_cen, sram_gwen, sram_a);
    else passed++;
    model_write(12'd5, DW'(8'hFF), '0);
    @(posedge clk); #1; drive_req(1'b0, 1'b0, '0, '0, '1); init_req = 1'b0;
    observe_sweep(2000, cyc, wr, oerr, rdy);
    checks++;
    if (cyc !== DEPTH || rdy !== 0 || req_rdy !== 1'b1)
      $display("FAIL reinit_rdy_low: got %0d cycles rdy-high=%0d, want %0d 0", cyc, rdy, DEPTH);
    else passed++;
    checks++;
    if (wr !== DEPTH || oerr !== 0) $display("FAIL reinit_writes: got %0d writes %0d out of order, want %0d 0", wr, oerr, DEPTH); else passed++;
    model_init();
    @(posedge clk); #1; drive_req(1'b1, 1'b0, 12'd5, '0, '0);
    @(posedge clk); #1; drive_req(1'b0, 1'b0, '0, '0, '1);
    @(negedge clk);
    checks++;
    if ({rd_vld, rd_data} !== {1'b1, exp_mem[5]})
      $display("FAIL reinit_readback: got vld=%b data=%h, want 1 %h", rd_vld, rd_data, exp_mem[5]);
    else passed++;
  endtask

  task automatic test_reset_mid_init();
    int cyc, wr, oerr, rdy;
    logic found;
    found = 1'b0;
    @(posedge clk); #1; init_req = 1'b1;
    @(posedge clk); #1; init_req = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(negedge clk);
      if (sram_cen === 1'b0 && sram_a === 12'd1000) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) $display("FAIL reach_cnt1000: got found=%b, want 1", found); else passed++;
    rst_n = 1'b0; #1;
    checks++;
    if ({sram_cen, sram_gwen, sram_wen, init_done, req_rdy, rd_vld} !== {2'b11, ONES, 3'b000})
      $display("FAIL async_reset: got cen=%b gwen=%b wen=%h done=%b rdy=%b rdvld=%b",
               sram_cen, sram_gwen, sram_wen, init_done, req_rdy, rd_vld);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    observe_sweep(0, cyc, wr, oerr, rdy);
    checks++;
    if (cyc !== DEPTH || wr !== DEPTH || oerr !== 0 || rdy !== 0)
      $display("FAIL restart_sweep: got cycles=%0d writes=%0d order_err=%0d rdy=%0d, want %0d %0d 0 0",
               cyc, wr, oerr, rdy, DEPTH, DEPTH);
    else passed++;
    model_init();
  endtask

  task automatic test_no_init();
    @(negedge clk);
    checks++;
    if ({sram_cen0, init_done0, req_rdy0, rd_vld0} !== 4'b1000)
      $display("FAIL noinit_reset: got cen=%b done=%b rdy=%b rdvld=%b, want 1 0 0 0", sram_cen0, init_done0, req_rdy0, rd_vld0);
    else passed++;
    rst0_n = 1'b1; #1;
    checks++;
    if ({sram_cen0, init_done0} !== 2'b10) $display("FAIL noinit_idle: got cen=%b done=%b, want 1 0", sram_cen0, init_done0);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({init_done0, req_rdy0} !== 2'b11) $display("FAIL noinit_done: got done=%b rdy=%b, want 1 1", init_done0, req_rdy0);
    else passed++;
    req0_vld = 1'b1; req0_addr = 12'd7; q0_pat = rand_word(); #1;
    checks++;
    if ({sram_cen0, sram_gwen0, sram_a0} !== {2'b01, 12'd7})
      $display("FAIL noinit_req: got cen=%b gwen=%b a=%h, want 0 1 007", sram_cen0, sram_gwen0, sram_a0);
    else passed++;
    @(posedge clk); #1; req0_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_vld0, rd_data0} !== {1'b1, q0_pat})
      $display("FAIL noinit_read: got vld=%b data=%h, want 1 %h", rd_vld0, rd_data0, q0_pat);
    else passed++;
    checks++;
    if (writes0 !== 0) $display("FAIL noinit_writes: got %0d, want 0", writes0); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_init_req();
    test_reset_mid_init();
    test_no_init();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
